adc_capture_sequencer: RTL
==========================

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: ADC sample width.
REQ-002 SHALL have parameter CNT_W, default 16: width of period and sample counters.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: run permission; low requests a graceful stop.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins a run from IDLE.
REQ-007 SHALL have port period, input, CNT_W: cycles between consecutive cnv rising edges.
REQ-008 SHALL have port cnv_high, input, 8: cnv high time in cycles.
REQ-009 SHALL have port capture_delay, input, 8: cycles from cnv fall to data latch.
REQ-010 SHALL have port num_samples, input, CNT_W: output samples per run; 0 means continuous.
REQ-011 SHALL have port data, input, DATA_W: ADC parallel result bus.
REQ-012 SHALL have port cnv, output, 1: ADC convert strobe, registered.
REQ-013 SHALL have port sample_valid / sample_data, outputs, 1 / DATA_W: valid/ready source toward the capture FIFO.
REQ-014 SHALL have port sample_ready, input, 1: FIFO accept; a transfer occurs when valid and ready are both high.
REQ-015 SHALL have ports busy, done, overrun, sample_count (outputs, 1/1/1/CNT_W): status.

Function
REQ-016 SHALL implement FSM states IDLE, CNV_HI, CAP_WAIT, PER_WAIT, DONE.
REQ-017 SHALL, in IDLE with start=1 and enable=1, latch period/cnv_high/capture_delay/num_samples, clear sample_count, and enter CNV_HI; start in any other state is ignored.
REQ-018 SHALL drive cnv=1 exactly for max(cnv_high,1) cycles in CNV_HI, starting the cycle after entry; the period counter starts on the cnv rising edge.
REQ-019 SHALL, in CAP_WAIT, count capture_delay cycles after cnv falls, then latch data in the following cycle (capture_delay=0 → latch on the first cycle after cnv fall).
REQ-020 SHALL enforce an effective period of max(period, cnv_high_eff + capture_delay + 2); PER_WAIT exits when the period counter reaches it.
REQ-021 SHALL present each output sample by registering it to sample_data and setting sample_valid the cycle after the latch; sample_data is held stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL, when a new output sample is produced while sample_valid is still high, drop the new sample, keep the pending one, and set overrun (sticky until reset or next start).
REQ-023 SHALL increment sample_count (wrapping modulo 2^CNT_W) on each accepted transfer.
REQ-024 SHALL, at PER_WAIT expiry, enter DONE if num_samples≠0 and the produced-sample count equals num_samples, otherwise re-enter CNV_HI.
REQ-025 SHALL, when enable falls mid-run, complete the current conversion and capture (never truncate cnv), then enter DONE instead of CNV_HI.
REQ-026 SHALL pulse done for exactly one cycle in DONE and then return to IDLE; a pending sample_valid persists until accepted.
REQ-027 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, enter IDLE regardless of state, aborting any conversion in progress.
REQ-029 SHALL reset cnv, sample_valid, busy, done, and overrun to 0, and sample_data and sample_count to 0.

Configuration
REQ-030 SHALL support the macro ADC_CAPTURE_AVG4_EN: when defined, each output sample is (sum of 4 consecutive captures, DATA_W+2-bit unsigned accumulator) >> 2, truncated, and num_samples counts averaged outputs; when undefined, every capture is an output sample and no accumulator exists.

Verification
REQ-031 SHALL test: period=20, cnv_high=3, capture_delay=4, num_samples=3, ready=1 → cnv rises at t, t+20, t+40; three transfers; done pulses once; sample_count=3.
REQ-032 SHALL test: period=5, cnv_high=3, capture_delay=4 → cnv rising-edge spacing is 9 cycles (clamped).
REQ-033 SHALL test: ready=0 for the full run, num_samples=2 → first sample held, overrun=1, sample_count=0 until ready asserts.
REQ-034 SHALL test: num_samples=0, enable dropped mid-CNV_HI → cnv completes its 3-cycle pulse, the sample is captured, done pulses, and the block returns to IDLE.
REQ-035 SHALL test: reset asserted during CAP_WAIT → next cycle cnv=0, busy=0, sample_valid=0; a later start runs normally.
REQ-036 SHALL test: with ADC_CAPTURE_AVG4_EN defined, data=100,101,102,104 → sample_data=101; without it → four samples 100,101,102,104.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: drives an ADC convert strobe (cnv) at a programmable
// period, latches the parallel result a programmable delay after cnv falls and
// presents each sample on a valid/ready source toward a capture FIFO.
// Optional build macro ADC_CAPTURE_AVG4_EN: every output sample is the
// truncated mean of 4 consecutive captures.
module adc_capture_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [CNT_W-1:0]  period,
  input  logic [7:0]        cnv_high,
  input  logic [7:0]        capture_delay,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [DATA_W-1:0] data,
  output logic              cnv,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int PW = CNT_W + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CNV_HI   = 3'd1;
  localparam logic [2:0] S_CAP_WAIT = 3'd2;
  localparam logic [2:0] S_PER_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        dly_q, dly_d;
  logic [CNT_W-1:0]  ns_q, ns_d;
  logic [PW-1:0]     per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  prod_q, prod_d;
  logic              cap_vld_q, cap_vld_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cnv_q, cnv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic              start_run;

  logic [PW-1:0] hi_eff, dly_ext, per_ext, min_per, per_eff;
  logic [PW-1:0] hi_end, cap_end, per_end;

`ifdef ADC_CAPTURE_AVG4_EN
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [1:0]        grp_q, grp_d;
  logic [DATA_W+1:0] acc_sum;

  function automatic logic [DATA_W-1:0] avg4_trunc(input logic [DATA_W+1:0] sum);
    return sum[DATA_W+1:2];
  endfunction
`endif

  // Effective timing: cnv high at least one cycle, period never shorter than
  // the high time plus capture delay plus latch and output cycles.
  always_comb begin
    hi_eff  = (hi_q == 8'd0) ? PW'(1) : PW'(hi_q);
    dly_ext = PW'(dly_q);
    per_ext = PW'(per_q);
    min_per = hi_eff + dly_ext + PW'(2);
    per_eff = (per_ext > min_per) ? per_ext : min_per;
    hi_end  = hi_eff - PW'(1);
    cap_end = hi_eff + dly_ext;
    per_end = per_eff - PW'(1);
  end

  // Sequencer FSM; per_cnt is zero in the first cnv-high cycle of each period.
  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    hi_d       = hi_q;
    dly_d      = dly_q;
    ns_d       = ns_q;
    per_cnt_d  = per_cnt_q + PW'(1);
    prod_d     = prod_q;
    cap_vld_d  = 1'b0;
    cap_data_d = cap_data_q;
    start_run  = 1'b0;
`ifdef ADC_CAPTURE_AVG4_EN
    acc_d   = acc_q;
    grp_d   = grp_q;
    acc_sum = acc_q + (DATA_W+2)'(data);
`endif
    case (state_q)
      S_IDLE: begin
        per_cnt_d = '0;
        if (start && enable) begin
          start_run = 1'b1;
          per_d     = period;
          hi_d      = cnv_high;
          dly_d     = capture_delay;
          ns_d      = num_samples;
          prod_d    = '0;
          state_d   = S_CNV_HI;
`ifdef ADC_CAPTURE_AVG4_EN
          acc_d = '0;
          grp_d = 2'd0;
`endif
        end
      end
      S_CNV_HI: begin
        if (per_cnt_q == hi_end) state_d = S_CAP_WAIT;
      end
      S_CAP_WAIT: begin
        if (per_cnt_q == cap_end) begin
          state_d = S_PER_WAIT;
`ifdef ADC_CAPTURE_AVG4_EN
          if (grp_q == 2'd3) begin
            cap_vld_d  = 1'b1;
            cap_data_d = avg4_trunc(acc_sum);
            prod_d     = prod_q + CNT_W'(1);
            acc_d      = '0;
            grp_d      = 2'd0;
          end else begin
            acc_d = acc_sum;
            grp_d = grp_q + 2'd1;
          end
`else
          cap_vld_d  = 1'b1;
          cap_data_d = data;
          prod_d     = prod_q + CNT_W'(1);
`endif
        end
      end
      S_PER_WAIT: begin
        if (per_cnt_q == per_end) begin
          per_cnt_d = '0;
          if (!enable || ((ns_q != '0) && (prod_q == ns_q))) state_d = S_DONE;
          else                                               state_d = S_CNV_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cnv_d  = (state_d == S_CNV_HI);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Output register: hold while stalled, drop new samples that arrive while
  // one is still pending and flag the overrun.
  always_comb begin
    sv_d   = sv_q & ~sample_ready;
    sd_d   = sd_q;
    ovr_d  = ovr_q;
    scnt_d = scnt_q + CNT_W'(sv_q & sample_ready);
    if (cap_vld_q) begin
      if (sv_q && !sample_ready) begin
        ovr_d = 1'b1;
      end else begin
        sv_d = 1'b1;
        sd_d = cap_data_q;
      end
    end
    if (start_run) begin
      scnt_d = '0;
      ovr_d  = 1'b0;
    end
  end

  // Control and status state, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cap_vld_q <= 1'b0;
      cnv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sv_q      <= 1'b0;
      sd_q      <= '0;
      ovr_q     <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cap_vld_q <= cap_vld_d;
      cnv_q     <= cnv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sv_q      <= sv_d;
      sd_q      <= sd_d;
      ovr_q     <= ovr_d;
      scnt_q    <= scnt_d;
    end
  end

  // Run configuration, counters and capture data; all initialised on start.
  always_ff @(posedge clk_in) begin
    per_q      <= per_d;
    hi_q       <= hi_d;
    dly_q      <= dly_d;
    ns_q       <= ns_d;
    per_cnt_q  <= per_cnt_d;
    prod_q     <= prod_d;
    cap_data_q <= cap_data_d;
`ifdef ADC_CAPTURE_AVG4_EN
    acc_q <= acc_d;
    grp_q <= grp_d;
`endif
  end

  assign cnv          = cnv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign sample_data  = sd_q;
  assign overrun      = ovr_q;
  assign sample_count = scnt_q;

endmodule
